// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the MAC/accumulator datapath:
//   - PRE_ADD / PRE_SUB : pre-adder operation codes (D+B / D-B)
//   - sat_add           : width-generic signed add with overflow detect and
//                         optional clamp. Operands are sign-extended into a
//                         SAT_W-bit container; the caller states the real
//                         accumulator width w (w <= SAT_W-1).
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int   SAT_W   = 128;
    localparam logic PRE_ADD = 1'b0;
    localparam logic PRE_SUB = 1'b1;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] sum;
    } sat_res_t;

    // Both operands must already be sign-extended values that fit in w bits.
    // The SAT_W-bit sum is exact, so overflow is a plain range test against
    // the w-bit signed limits. With sat=0 the caller truncates to w bits,
    // which yields the two's-complement wrap.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w,
        input logic                    sat
    );
        sat_res_t                res;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] vmax;
        logic signed [SAT_W-1:0] vmin;
        s        = a + b;
        vmax     = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        vmin     = ~vmax;
        res.ovf  = (s > vmax) || (s < vmin);
        res.sum  = s;
        if (sat && (s > vmax)) begin
            res.sum = vmax;
        end else if (sat && (s < vmin)) begin
            res.sum = vmin;
        end
        return res;
    endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// -----------------------------------------------------------------------------
// dsp_pipe_reg
// W-bit pipeline register with clock enable and synchronous active-low reset.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous reset, active low, clears q to 0 regardless of i_ce
//   i_ce    : clock enable; 0 holds q
//   i_d     : data in
//   o_q     : registered data out
// -----------------------------------------------------------------------------
module dsp_pipe_reg #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_ce) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/dsp_mac_accum.sv
// -----------------------------------------------------------------------------
// dsp_mac_accum
// Pre-adder -> multiplier -> frame accumulator. Signed samples arrive with a
// valid/last handshake; each frame is summed starting from its C bias and one
// P result pulse is produced per frame (latency 4 with MREG=1, 3 with MREG=0,
// counted in PCE=1 cycles).
// Ports:
//   PCLK, PRSTN (sync, active low), PCE (global clock enable)
//   IN_VALID, IN_LAST            : sample handshake
//   A, B, D, C                   : multiplicand, pre-adder operands, frame bias
//   PRE_EN, PRE_SUB              : pre-adder enable / operation
//   P, OUT_VALID, OVF, BUSY      : frame result, result pulse, frame overflow,
//                                  frame open at the accumulator
// -----------------------------------------------------------------------------
module dsp_mac_accum #(
    parameter int A_W      = 18,
    parameter int B_W      = 18,
    parameter int P_W      = 48,
    parameter int MREG     = 1,
    parameter int SATURATE = 0
) (
    input  logic           PCLK,
    input  logic           PRSTN,
    input  logic           PCE,
    input  logic           IN_VALID,
    input  logic           IN_LAST,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic [B_W-1:0] D,
    input  logic [P_W-1:0] C,
    input  logic           PRE_EN,
    input  logic           PRE_SUB,
    output logic [P_W-1:0] P,
    output logic           OUT_VALID,
    output logic           OVF,
    output logic           BUSY
);

    import dsp_pkg::*;

    localparam int M_W  = A_W + B_W + 1;
    localparam int S1_W = A_W + 2 * B_W + P_W + 4;
    localparam int S2_W = (B_W + 1) + A_W + P_W + 2;
    localparam int S3_W = M_W + P_W + 2;

    generate
        if (P_W < M_W || P_W > SAT_W - 1) begin : g_bad_pw
            $error("dsp_mac_accum: P_W must be in [A_W+B_W+1, %0d]", SAT_W - 1);
        end
    endgenerate

    // ---------------- S1: input capture ----------------
    logic [S1_W-1:0]  w_s1_q;
    logic [A_W-1:0]   w_s1_a;
    logic [B_W-1:0]   w_s1_b;
    logic [B_W-1:0]   w_s1_dop;
    logic [P_W-1:0]   w_s1_c;
    logic             w_s1_en;
    logic             w_s1_sub;
    logic             w_s1_v;
    logic             w_s1_l;

    // LAST is qualified with VALID here so it never needs re-qualifying.
    dsp_pipe_reg #(.W(S1_W)) u_s1 (
        .i_clk   (PCLK),
        .i_rst_n (PRSTN),
        .i_ce    (PCE),
        .i_d     ({A, B, D, C, PRE_EN, PRE_SUB, IN_VALID, IN_VALID & IN_LAST}),
        .o_q     (w_s1_q)
    );
    assign {w_s1_a, w_s1_b, w_s1_dop, w_s1_c, w_s1_en, w_s1_sub, w_s1_v, w_s1_l} = w_s1_q;

    // ---------------- S2: pre-adder ----------------
    logic signed [B_W:0] w_b_x;
    logic signed [B_W:0] w_d_x;
    logic signed [B_W:0] w_pre;

    assign w_b_x = {w_s1_b[B_W-1], w_s1_b};
    assign w_d_x = {w_s1_dop[B_W-1], w_s1_dop};

    always_comb begin
        w_pre = w_b_x;
        if (w_s1_en) begin
            w_pre = (w_s1_sub == dsp_pkg::PRE_SUB) ? (w_d_x - w_b_x) : (w_d_x + w_b_x);
        end
    end

    logic [S2_W-1:0]  w_s2_q;
    logic [B_W:0]     w_s2_pre;
    logic [A_W-1:0]   w_s2_a;
    logic [P_W-1:0]   w_s2_c;
    logic             w_s2_v;
    logic             w_s2_l;

    dsp_pipe_reg #(.W(S2_W)) u_s2 (
        .i_clk   (PCLK),
        .i_rst_n (PRSTN),
        .i_ce    (PCE),
        .i_d     ({w_pre, w_s1_a, w_s1_c, w_s1_v, w_s1_l}),
        .o_q     (w_s2_q)
    );
    assign {w_s2_pre, w_s2_a, w_s2_c, w_s2_v, w_s2_l} = w_s2_q;

    // ---------------- S3: multiplier ----------------
    // Both factors are widened to M_W; the true product always fits in M_W.
    logic signed [M_W-1:0] w_mul_pre;
    logic signed [M_W-1:0] w_mul_a;
    logic signed [M_W-1:0] w_mul;

    assign w_mul_pre = {{A_W{w_s2_pre[B_W]}}, w_s2_pre};
    assign w_mul_a   = {{(B_W + 1){w_s2_a[A_W-1]}}, w_s2_a};
    assign w_mul     = w_mul_pre * w_mul_a;

    logic [S3_W-1:0]  w_s3_d;
    logic [S3_W-1:0]  w_s3_q;
    logic [M_W-1:0]   w_s3_m;
    logic [P_W-1:0]   w_s3_c;
    logic             w_s3_v;
    logic             w_s3_l;

    assign w_s3_d = {w_mul, w_s2_c, w_s2_v, w_s2_l};

    generate
        if (MREG != 0) begin : g_mreg
            dsp_pipe_reg #(.W(S3_W)) u_s3 (
                .i_clk   (PCLK),
                .i_rst_n (PRSTN),
                .i_ce    (PCE),
                .i_d     (w_s3_d),
                .o_q     (w_s3_q)
            );
        end else begin : g_no_mreg
            assign w_s3_q = w_s3_d;
        end
    endgenerate
    assign {w_s3_m, w_s3_c, w_s3_v, w_s3_l} = w_s3_q;

    // ---------------- S4: accumulator ----------------
    logic [P_W-1:0] r_acc;
    logic           r_first;
    logic           r_ovf_frame;
    logic [P_W-1:0] r_p;
    logic           r_out_valid;
    logic           r_ovf;

    logic [P_W-1:0]     w_base;
    sat_res_t           w_add;
    logic [P_W-1:0]     w_acc_next;
    logic               w_frame_ovf;
    logic [SAT_W-P_W-1:0] w_unused_hi;

    // First sample of a frame starts from its own C, discarding the old acc.
    assign w_base      = r_first ? w_s3_c : r_acc;
    assign w_add       = sat_add({{(SAT_W - P_W){w_base[P_W-1]}}, w_base},
                                 {{(SAT_W - M_W){w_s3_m[M_W-1]}}, w_s3_m},
                                 P_W, (SATURATE != 0));
    assign w_acc_next  = w_add.sum[P_W-1:0];
    assign w_unused_hi = w_add.sum[SAT_W-1:P_W];
    // Sticky frame flag: restarts on the first sample of each frame.
    assign w_frame_ovf = (r_first ? 1'b0 : r_ovf_frame) | w_add.ovf;

    always_ff @(posedge PCLK) begin
        if (!PRSTN) begin
            r_acc       <= '0;
            r_first     <= 1'b1;
            r_ovf_frame <= 1'b0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (PCE) begin
            r_out_valid <= w_s3_v & w_s3_l;
            if (w_s3_v) begin
                r_acc       <= w_acc_next;
                r_ovf_frame <= w_frame_ovf;
                r_first     <= w_s3_l;
                if (w_s3_l) begin
                    r_p   <= w_acc_next;
                    r_ovf <= w_frame_ovf;
                end
            end
        end
    end

    assign P         = r_p;
    assign OUT_VALID = r_out_valid;
    assign OVF       = r_ovf;
    assign BUSY      = ~r_first;

endmodule

// File: tb/tb_dsp_mac_accum.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_accum
// Two instances share all inputs: u_sat (MREG=1, SATURATE=1) and
// u_wrap (MREG=0, SATURATE=0), both with A_W=B_W=8, P_W=17 = A_W+B_W+1.
// Table of single-sample frames, then hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_dsp_mac_accum;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = 17;

    logic          PCLK = 1'b0;
    logic          PRSTN, PCE, IN_VALID, IN_LAST, PRE_EN, PRE_SUB;
    logic [AW-1:0] A;
    logic [BW-1:0] B, D;
    logic [PW-1:0] C;
    logic [PW-1:0] p_s, p_w;
    logic          ov_s, ovf_s, busy_s, ov_w, ovf_w, busy_w;

    always #5 PCLK = ~PCLK;

    dsp_mac_accum #(.A_W(AW), .B_W(BW), .P_W(PW), .MREG(1), .SATURATE(1)) u_sat (
        .PCLK(PCLK), .PRSTN(PRSTN), .PCE(PCE), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
        .A(A), .B(B), .D(D), .C(C), .PRE_EN(PRE_EN), .PRE_SUB(PRE_SUB),
        .P(p_s), .OUT_VALID(ov_s), .OVF(ovf_s), .BUSY(busy_s)
    );

    dsp_mac_accum #(.A_W(AW), .B_W(BW), .P_W(PW), .MREG(0), .SATURATE(0)) u_wrap (
        .PCLK(PCLK), .PRSTN(PRSTN), .PCE(PCE), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
        .A(A), .B(B), .D(D), .C(C), .PRE_EN(PRE_EN), .PRE_SUB(PRE_SUB),
        .P(p_w), .OUT_VALID(ov_w), .OVF(ovf_w), .BUSY(busy_w)
    );

    typedef struct {
        int   a, b, d, c;
        logic en, sub;
        int   exp_p;
        logic exp_ovf;
    } vec_t;

    vec_t vt[8];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive(input logic pce, input logic v, input logic l,
                         input int a, input int b, input int d, input int c,
                         input logic en, input logic sub);
        PCE      = pce;
        IN_VALID = v;
        IN_LAST  = l;
        A        = AW'(a);
        B        = BW'(b);
        D        = BW'(d);
        C        = PW'(c);
        PRE_EN   = en;
        PRE_SUB  = sub;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        // a, b, d, c, en, sub, expected P (17-bit signed, saturating), ovf
        vt[0] = '{3, 4, 5, 10, 1'b1, 1'b0, 37, 1'b0};
        vt[1] = '{-7, 3, 10, 0, 1'b1, 1'b1, -49, 1'b0};
        vt[2] = '{5, -6, 100, -20, 1'b0, 1'b0, -50, 1'b0};
        vt[3] = '{-128, 127, -128, 1000, 1'b1, 1'b1, 33640, 1'b0};
        vt[4] = '{127, 127, 127, -30000, 1'b1, 1'b0, 2258, 1'b0};
        vt[5] = '{0, 50, 50, 12345, 1'b1, 1'b0, 12345, 1'b0};
        vt[6] = '{-1, -128, 0, -1, 1'b0, 1'b1, 127, 1'b0};
        vt[7] = '{-128, -128, -128, 40000, 1'b1, 1'b0, 65535, 1'b1};

        // ---- reset ----
        PRSTN = 1'b0;
        idle();
        tick();
        tick();
        PRSTN = 1'b1;
        chk("rst_p", $signed(p_s), 0);
        chk("rst_ov", ov_s, 0);
        chk("rst_ovf", ovf_s, 0);
        chk("rst_busy", busy_s, 0);
        $display("reset: P=%0d OUT_VALID=%0b OVF=%0b BUSY=%0b", $signed(p_s), ov_s, ovf_s, busy_s);

        // ---- isolated single-sample frames: latency 4 ----
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, vt[i].a, vt[i].b, vt[i].d, vt[i].c, vt[i].en, vt[i].sub);
            tick();
            idle();
            tick();
            tick();
            chk("single_early_ov", ov_s, 0);
            tick();
            chk("single_ov", ov_s, 1);
            chk("single_p", $signed(p_s), vt[i].exp_p);
            chk("single_ovf", ovf_s, vt[i].exp_ovf);
            $display("single frame %0d: P=%0d OVF=%0b", i, $signed(p_s), ovf_s);
        end
        tick();

        // ---- back-to-back single-sample frames: continuous OUT_VALID ----
        for (int t = 0; t < 11; t++) begin
            if (t < 8) drive(1'b1, 1'b1, 1'b1, vt[t].a, vt[t].b, vt[t].d, vt[t].c, vt[t].en, vt[t].sub);
            else idle();
            tick();
            if (t >= 3) begin
                chk("stream_ov", ov_s, 1);
                chk("stream_p", $signed(p_s), vt[t-3].exp_p);
                chk("stream_ovf", ovf_s, vt[t-3].exp_ovf);
                $display("stream frame %0d: P=%0d", t - 3, $signed(p_s));
            end
        end
        idle();
        tick();
        chk("stream_end_ov", ov_s, 0);

        // ---- 4-sample frame, pre = 0 - 1 = -1, M = -2, C = 0 -> -8 ----
        for (int t = 0; t < 9; t++) begin
            if (t < 4) drive(1'b1, 1'b1, (t == 3), 2, 1, 0, 0, 1'b1, 1'b1);
            else idle();
            tick();
            chk("f4_ov", ov_s, (t == 6));
            chk("f4_busy", busy_s, (t >= 3 && t < 6));
            if (t == 5) chk("f4_wrap_p", $signed(p_w), -8);
            if (t == 6) begin
                chk("f4_p", $signed(p_s), -8);
                chk("f4_ovf", ovf_s, 0);
                $display("4-sample frame: P=%0d", $signed(p_s));
            end
        end

        // ---- back-to-back 2-sample frames, C=100 then C=0, M=5 ----
        for (int t = 0; t < 8; t++) begin
            case (t)
                0: drive(1'b1, 1'b1, 1'b0, 5, 1, 0, 100, 1'b0, 1'b0);
                1: drive(1'b1, 1'b1, 1'b1, 5, 1, 0, 999, 1'b0, 1'b0);
                2: drive(1'b1, 1'b1, 1'b0, 5, 1, 0, 0, 1'b0, 1'b0);
                3: drive(1'b1, 1'b1, 1'b1, 5, 1, 0, 777, 1'b0, 1'b0);
                default: idle();
            endcase
            tick();
            chk("b2b_ov", ov_s, (t == 4 || t == 6));
            if (t == 4) chk("b2b_p1", $signed(p_s), 110);
            if (t == 6) chk("b2b_p2", $signed(p_s), 10);
            if (t == 4 || t == 6) $display("b2b frame: P=%0d", $signed(p_s));
        end

        // ---- 3 max products (32768 each): sat clamps, wrap wraps ----
        for (int t = 0; t < 7; t++) begin
            if (t < 3) drive(1'b1, 1'b1, (t == 2), -128, -128, -128, 0, 1'b1, 1'b0);
            else idle();
            tick();
            chk("sat_ov", ov_s, (t == 5));
            chk("wrap_ov", ov_w, (t == 4));
            if (t == 5) begin
                chk("sat_p", $signed(p_s), 65535);
                chk("sat_ovf", ovf_s, 1);
                $display("saturating frame: P=%0d OVF=%0b", $signed(p_s), ovf_s);
            end
            if (t == 4) begin
                chk("wrap_p", $signed(p_w), -32768);
                chk("wrap_ovf", ovf_w, 1);
                $display("wrapping frame: P=%0d OVF=%0b", $signed(p_w), ovf_w);
            end
        end
        // clean frame afterwards: M = 1, C = 0
        for (int t = 0; t < 5; t++) begin
            if (t == 0) drive(1'b1, 1'b1, 1'b1, 1, 1, 0, 0, 1'b0, 1'b0);
            else idle();
            tick();
            if (t == 2) begin
                chk("clean_wrap_p", $signed(p_w), 1);
                chk("clean_wrap_ovf", ovf_w, 0);
            end
            if (t == 3) begin
                chk("clean_p", $signed(p_s), 1);
                chk("clean_ovf", ovf_s, 0);
                $display("clean frame: P=%0d OVF=%0b", $signed(p_s), ovf_s);
            end
        end

        // ---- PCE stall (3 cycles) and bubble inside a 3-sample frame ----
        // M = 3*3 = 9, C = 5 -> 32; last captured at t=6, output at t=9
        for (int t = 0; t < 12; t++) begin
            case (t)
                0: drive(1'b1, 1'b1, 1'b0, 3, 2, 1, 5, 1'b1, 1'b0);
                1: drive(1'b1, 1'b0, 1'b1, 50, 9, 9, 321, 1'b1, 1'b0);
                2: drive(1'b1, 1'b1, 1'b0, 3, 2, 1, 888, 1'b1, 1'b0);
                3: drive(1'b0, 1'b1, 1'b1, 100, 7, 7, 444, 1'b1, 1'b0);
                4, 5: drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
                6: drive(1'b1, 1'b1, 1'b1, 3, 2, 1, 888, 1'b1, 1'b0);
                default: idle();
            endcase
            tick();
            chk("pce_ov", ov_s, (t == 9));
            chk("pce_wrap_ov", ov_w, (t == 8));
            if (t == 4) chk("pce_frozen_p", $signed(p_s), 1);
            if (t == 8) chk("pce_wrap_p", $signed(p_w), 32);
            if (t == 9) begin
                chk("pce_p", $signed(p_s), 32);
                chk("pce_ovf", ovf_s, 0);
                $display("stalled frame: P=%0d", $signed(p_s));
            end
        end

        // ---- reset mid-frame, then 1-sample frame C=7, M=6 -> 13 ----
        for (int t = 0; t < 10; t++) begin
            PRSTN = (t != 4);
            if (t < 4) drive(1'b1, 1'b1, 1'b0, 2, 3, 0, (t == 0) ? 50 : 0, 1'b0, 1'b0);
            else if (t == 4) drive(1'b1, 1'b1, 1'b1, 2, 3, 0, 0, 1'b0, 1'b0);
            else if (t == 5) drive(1'b1, 1'b1, 1'b1, 2, 3, 0, 7, 1'b0, 1'b0);
            else idle();
            tick();
            if (t == 3) chk("mrst_busy_before", busy_s, 1);
            if (t == 4) begin
                chk("mrst_p", $signed(p_s), 0);
                chk("mrst_ovf", ovf_s, 0);
                chk("mrst_busy", busy_s, 0);
                chk("mrst_wrap_p", $signed(p_w), 0);
                $display("mid-frame reset: P=%0d BUSY=%0b", $signed(p_s), busy_s);
            end
            if (t >= 4) begin
                chk("mrst_ov", ov_s, (t == 8));
                chk("mrst_wrap_ov", ov_w, (t == 7));
            end
            if (t == 7) chk("mrst_wrap_next_p", $signed(p_w), 13);
            if (t == 8) begin
                chk("mrst_next_p", $signed(p_s), 13);
                $display("post-reset frame: P=%0d", $signed(p_s));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
